// File: rtl/mod_exp_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mod_exp_engine
// Description : Modular exponentiation value^exponent mod modulus using
//               right-to-left square-and-multiply over a bit-serial
//               interleaved (Blakley) modular multiplier.
//               Optional macro MODEXP_CONST_TIME_EN: always processes all
//               EXP_WIDTH exponent bits (no early exit).
// Revision    : 1.0 - initial release
// ============================================================================
module mod_exp_engine #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 ready_in,
    input  logic                 abort_in,
    input  logic [WIDTH-1:0]     value_in,
    input  logic [EXP_WIDTH-1:0] exponent_in,
    input  logic [WIDTH-1:0]     modulus_in,
    output logic [WIDTH-1:0]     value_out,
    output logic                 busy_out,
    output logic                 valid_out,
    output logic                 error_out
);

    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_REDUCE = 3'd1;
    localparam logic [2:0] c_CHECK  = 3'd2;
    localparam logic [2:0] c_MUL    = 3'd3;
    localparam logic [2:0] c_SQR    = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [WIDTH-1:0]     r_m;       // captured modulus
    logic [WIDTH-1:0]     r_b;       // running base power b^(2^k) mod m
    logic [WIDTH-1:0]     r_res;     // running result
    logic [WIDTH-1:0]     r_acc;     // reduction / multiplier accumulator (always < m)
    logic [WIDTH-1:0]     r_shift;   // serial operand, consumed MSB first
    logic [EXP_WIDTH-1:0] r_e;       // remaining exponent bits
    logic [c_CNT_W-1:0]   r_cnt;     // step counter within REDUCE/MUL/SQR
    logic                 w_last;
    logic                 w_exp_done;
    logic [WIDTH+1:0]     w_m_ext;
    logic [WIDTH+1:0]     w_addend;
    logic [WIDTH+1:0]     w_dbl;
    logic [WIDTH+1:0]     w_sub1;
    logic [WIDTH-1:0]     w_step;

    assign w_last    = (r_cnt == c_CNT_LAST);
    assign w_m_ext   = {2'b00, r_m};
    assign busy_out  = (r_state == c_REDUCE) || (r_state == c_CHECK) ||
                       (r_state == c_MUL)    || (r_state == c_SQR);
    assign valid_out = (r_state == c_DONE);

`ifdef MODEXP_CONST_TIME_EN
    localparam int                  c_BITS_W   = $clog2(EXP_WIDTH + 1);
    localparam logic [c_BITS_W-1:0] c_BITS_ALL = c_BITS_W'(EXP_WIDTH);
    localparam logic [c_BITS_W-1:0] c_BITS_ONE = c_BITS_W'(1);
    logic [c_BITS_W-1:0] r_bits;

    // Count exponent bits fully processed (one per completed squaring)
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_bits <= '0;
        end else if ((r_state == c_IDLE) && ready_in) begin
            r_bits <= '0;
        end else if ((r_state == c_SQR) && w_last) begin
            r_bits <= r_bits + c_BITS_ONE;
        end
    end

    assign w_exp_done = (r_bits == c_BITS_ALL);
`else
    assign w_exp_done = (r_e == '0);
`endif

    // One shared datapath step: acc = 2*acc + addend, then fold back below m.
    // In REDUCE the addend is the next base bit, so one fold already suffices.
    always_comb begin
        w_addend = '0;
        if (r_state == c_REDUCE) begin
            w_addend = {{(WIDTH + 1){1'b0}}, r_shift[WIDTH-1]};
        end else if (r_shift[WIDTH-1]) begin
            w_addend = {2'b00, r_b};
        end
        w_dbl  = {1'b0, r_acc, 1'b0} + w_addend;
        w_sub1 = (w_dbl >= w_m_ext) ? (w_dbl - w_m_ext) : w_dbl;
        w_step = (w_sub1 >= w_m_ext) ? WIDTH'(w_sub1 - w_m_ext) : w_sub1[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; abort wins everywhere except IDLE and DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (ready_in) w_next = (modulus_in == '0) ? c_DONE : c_REDUCE;
            c_REDUCE: if (w_last) w_next = c_CHECK;
            c_CHECK: begin
                if (w_exp_done)  w_next = c_DONE;
                else if (r_e[0]) w_next = c_MUL;
                else             w_next = c_SQR;
            end
            c_MUL:    if (w_last) w_next = c_SQR;
            c_SQR:    if (w_last) w_next = c_CHECK;
            c_DONE:   w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
        if (abort_in && (r_state != c_IDLE) && (r_state != c_DONE)) begin
            w_next = c_IDLE;
        end
    end

    // Operand capture, serial arithmetic and result/error registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_m       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_acc     <= '0;
            r_shift   <= '0;
            r_e       <= '0;
            r_cnt     <= '0;
            value_out <= '0;
            error_out <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (ready_in) begin
                        r_m       <= modulus_in;
                        r_e       <= exponent_in;
                        r_shift   <= value_in;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        error_out <= (modulus_in == '0);
                        if (modulus_in == '0) begin
                            value_out <= '0;
                        end
                    end
                end
                c_REDUCE: begin
                    r_acc   <= w_step;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + c_CNT_ONE;
                    if (w_last) begin
                        r_b   <= w_step;
                        r_res <= (r_m == WIDTH'(1)) ? '0 : WIDTH'(1);
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                c_CHECK: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    if (w_next == c_DONE) begin
                        value_out <= r_res;
                    end else if (w_next == c_MUL) begin
                        r_shift <= r_res;
                    end else if (w_next == c_SQR) begin
                        r_shift <= r_b;
                    end
                end
                c_MUL: begin
                    r_acc   <= w_step;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + c_CNT_ONE;
                    if (w_last) begin
                        r_res   <= w_step;
                        r_shift <= r_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                c_SQR: begin
                    r_acc   <= w_step;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + c_CNT_ONE;
                    if (w_last) begin
                        r_b   <= w_step;
                        r_e   <= r_e >> 1;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_exp_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mod_exp_engine
// Description : Self-checking bench for mod_exp_engine (WIDTH=16,
//               EXP_WIDTH=16): directed vector table, handshake corner
//               sequences and a random sweep against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_exp_engine;

    localparam int W  = 16;
    localparam int EW = 16;
`ifdef MODEXP_CONST_TIME_EN
    localparam bit c_CT = 1'b1;
`else
    localparam bit c_CT = 1'b0;
`endif
    localparam int c_NVEC  = 9;
    localparam int c_NRAND = 150;
    localparam int c_LIMIT = 2000;

    logic          clk_in      = 1'b0;
    logic          rst_n_in    = 1'b0;
    logic          ready_in    = 1'b0;
    logic          abort_in    = 1'b0;
    logic [W-1:0]  value_in    = '0;
    logic [EW-1:0] exponent_in = '0;
    logic [W-1:0]  modulus_in  = '0;
    logic [W-1:0]  value_out;
    logic          busy_out;
    logic          valid_out;
    logic          error_out;

    int total = 0;
    int bad   = 0;

    mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .ready_in    (ready_in),
        .abort_in    (abort_in),
        .value_in    (value_in),
        .exponent_in (exponent_in),
        .modulus_in  (modulus_in),
        .value_out   (value_out),
        .busy_out    (busy_out),
        .valid_out   (valid_out),
        .error_out   (error_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] v;
        logic [15:0] e;
        logic [15:0] m;
        logic [15:0] val;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [c_NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Plain square-and-multiply with wide integers
    function automatic logic [15:0] ref_modexp(input logic [15:0] v, input logic [15:0] e,
                                               input logic [15:0] m);
        longint unsigned r, b, mm;
        if (m == 16'd0) return 16'd0;
        mm = longint'(m);
        r  = 64'd1 % mm;
        b  = longint'(v) % mm;
        for (int k = 0; k < 16; k++) begin
            if (e[k]) r = (r * b) % mm;
            b = (b * b) % mm;
        end
        return 16'(r);
    endfunction

    // Cycles from capture edge to valid_out, from the documented formula
    function automatic int ref_lat(input logic [15:0] e);
        int n  = 0;
        int pc = 0;
        for (int k = 0; k < 16; k++) begin
            if (e[k]) begin
                n = k + 1;
                pc++;
            end
        end
        if (c_CT) return W + EW + W * (EW + pc) + 1;
        return W + n + W * (n + pc) + 1;
    endfunction

    task automatic start_op(input logic [15:0] v, input logic [15:0] e, input logic [15:0] m);
        @(negedge clk_in);
        value_in    = v;
        exponent_in = e;
        modulus_in  = m;
        ready_in    = 1'b1;
        @(negedge clk_in);
        ready_in    = 1'b0;
        value_in    = ~v;
        exponent_in = ~e;
        modulus_in  = m ^ 16'h5a5a;
    endtask

    // Wait for valid_out, checking busy/valid exclusivity every cycle
    task automatic wait_valid(input int start_cyc, output int lat, output bit got);
        int c;
        c   = start_cyc;
        got = 1'b0;
        while (c < c_LIMIT) begin
            check("busy_valid_overlap", {31'd0, busy_out & valid_out}, 32'd0);
            if (valid_out) begin
                got = 1'b1;
                break;
            end
            check("busy_while_running", {31'd0, busy_out}, 32'd1);
            @(negedge clk_in);
            c++;
        end
        lat = c;
    endtask

    task automatic finish_check(input string tag, input bit got, input int lat,
                                input logic [15:0] ev, input logic ee, input int el);
        check({tag, "_timeout"}, {31'd0, got}, 32'd1);
        if (got) begin
            check({tag, "_value"}, {16'd0, value_out}, {16'd0, ev});
            check({tag, "_error"}, {31'd0, error_out}, {31'd0, ee});
            check({tag, "_latency"}, lat, el);
            @(negedge clk_in);
            check({tag, "_valid_pulse"}, {31'd0, valid_out}, 32'd0);
            check({tag, "_busy_after"}, {31'd0, busy_out}, 32'd0);
            check({tag, "_value_held"}, {16'd0, value_out}, {16'd0, ev});
            check({tag, "_error_held"}, {31'd0, error_out}, {31'd0, ee});
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] v, input logic [15:0] e,
                          input logic [15:0] m, input logic [15:0] ev, input logic ee,
                          input int el);
        int lat;
        bit got;
        start_op(v, e, m);
        wait_valid(0, lat, got);
        finish_check(tag, got, lat, ev, ee, el);
    endtask

    initial begin
        int          lat;
        bit          got;
        logic [15:0] rv, re, rm;

        vecs[0] = '{16'd4,     16'd13,    16'd497,   16'd445, 1'b0, c_CT ? 337 : 133};
        vecs[1] = '{16'd300,   16'd0,     16'd7,     16'd1,   1'b0, c_CT ? 289 : 17};
        vecs[2] = '{16'd300,   16'd0,     16'd1,     16'd0,   1'b0, c_CT ? 289 : 17};
        vecs[3] = '{16'd5,     16'd3,     16'd0,     16'd0,   1'b1, 0};
        vecs[4] = '{16'd2,     16'd10,    16'd1000,  16'd24,  1'b0, c_CT ? 321 : 117};
        vecs[5] = '{16'd3,     16'd1,     16'd5,     16'd3,   1'b0, c_CT ? 305 : 50};
        vecs[6] = '{16'd65535, 16'd65535, 16'd65535, 16'd0,   1'b0, 545};
        vecs[7] = '{16'd65534, 16'd2,     16'd65535, 16'd1,   1'b0, c_CT ? 305 : 67};
        vecs[8] = '{16'd2,     16'd16,    16'd65521, 16'd15,  1'b0, c_CT ? 305 : 118};

        // Reset state
        repeat (3) @(negedge clk_in);
        check("reset_value", {16'd0, value_out}, 32'd0);
        check("reset_busy", {31'd0, busy_out}, 32'd0);
        check("reset_valid", {31'd0, valid_out}, 32'd0);
        check("reset_error", {31'd0, error_out}, 32'd0);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // Directed table
        for (int i = 0; i < c_NVEC; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].v, vecs[i].e, vecs[i].m,
                   vecs[i].val, vecs[i].err, vecs[i].lat);
        end

        // Abort 40 cycles after capture, then immediate new start
        start_op(16'd4, 16'd13, 16'd497);
        repeat (39) begin
            check("abort_no_early_valid", {31'd0, valid_out}, 32'd0);
            @(negedge clk_in);
        end
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        check("abort_busy", {31'd0, busy_out}, 32'd0);
        check("abort_valid", {31'd0, valid_out}, 32'd0);
        check("abort_value_kept", {16'd0, value_out}, 32'd15);
        run_op("after_abort", 16'd2, 16'd10, 16'd1000, 16'd24, 1'b0, ref_lat(16'd10));

        // Abort while idle has no effect
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        @(negedge clk_in);
        check("idle_abort_busy", {31'd0, busy_out}, 32'd0);
        check("idle_abort_valid", {31'd0, valid_out}, 32'd0);
        check("idle_abort_value", {16'd0, value_out}, 32'd24);

        // Start request while busy is ignored
        start_op(16'd4, 16'd13, 16'd497);
        repeat (9) @(negedge clk_in);
        value_in    = 16'd9;
        exponent_in = 16'd9;
        modulus_in  = 16'd11;
        ready_in    = 1'b1;
        @(negedge clk_in);
        ready_in    = 1'b0;
        wait_valid(10, lat, got);
        finish_check("ready_while_busy", got, lat, 16'd445, 1'b0, ref_lat(16'd13));

        // Asynchronous reset mid-operation
        start_op(16'd3, 16'd200, 16'd1009);
        repeat (20) @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        check("midreset_value", {16'd0, value_out}, 32'd0);
        check("midreset_busy", {31'd0, busy_out}, 32'd0);
        check("midreset_valid", {31'd0, valid_out}, 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Error, then asynchronous reset in idle clears error_out
        run_op("err_again", 16'd5, 16'd3, 16'd0, 16'd0, 1'b1, 0);
        #2 rst_n_in = 1'b0;
        #1;
        check("idle_reset_error", {31'd0, error_out}, 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Random sweep against the reference model
        for (int i = 0; i < c_NRAND; i++) begin
            rv = 16'($urandom);
            re = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rm = 16'($urandom_range(1, 3));
            else                           rm = 16'($urandom_range(1, 65535));
            run_op($sformatf("rand%0d", i), rv, re, rm, ref_modexp(rv, re, rm), 1'b0,
                   ref_lat(re));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
